// File: rtl/pc_gen.sv
// Fetch-address generator: issues sequential PCs over valid/ready, redirects on trap/jump with epoch tagging.
// Credit counter bounds in-flight fetches; a redirect costs two request-free cycles.
module pc_gen #(
  parameter int                    DATA_WIDTH      = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR    = 32'h3000_0000,
  parameter int                    STEP            = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter int                    EPOCH_WIDTH     = 2,
  localparam int                   IW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_WIDTH-1:0]  pc_o,
  output logic [EPOCH_WIDTH-1:0] out_epoch_o,
  input  logic                   jump_i,
  input  logic [DATA_WIDTH-1:0]  upc_i,
  input  logic                   trap_valid_i,
  input  logic [DATA_WIDTH-1:0]  trap_pc_i,
  input  logic                   resp_done_i,
  output logic [IW-1:0]          inflight_o,
  output logic                   err_o
);

  localparam logic [DATA_WIDTH-1:0] STEP_W     = DATA_WIDTH'(STEP);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~(STEP_W - DATA_WIDTH'(1));
  localparam logic [IW-1:0]         MAX_CNT    = IW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {BOOT, RUN, BUBBLE} state_e;

  state_e                 state_q;
  logic [DATA_WIDTH-1:0]  pc_q, pc_d;
  logic [EPOCH_WIDTH-1:0] epoch_q, epoch_d;
  logic [IW-1:0]          inflight_q, inflight_d;
  logic                   err_q, err_d;

  logic                  redir, fire, credit_ret;
  logic [DATA_WIDTH-1:0] target;

  always_comb begin
    redir       = trap_valid_i | jump_i;
    target      = (trap_valid_i ? trap_pc_i : upc_i) & ALIGN_MASK;
    // Gating on redir guarantees a fire never coincides with a redirect.
    out_valid_o = (state_q == RUN) & ~redir & (inflight_q < MAX_CNT);
    fire        = out_valid_o & out_ready_i;
    credit_ret  = resp_done_i & (inflight_q != '0);
  end

  always_comb begin
    pc_d    = pc_q;
    epoch_d = epoch_q;
    if (redir) begin
      pc_d    = target;
      epoch_d = epoch_q + EPOCH_WIDTH'(1);
    end else if (fire) begin
      pc_d    = pc_q + STEP_W;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({fire, credit_ret})
      2'b10:   inflight_d = inflight_q + IW'(1);
      2'b01:   inflight_d = inflight_q - IW'(1);
      default: inflight_d = inflight_q;
    endcase
    err_d = err_q | (resp_done_i & (inflight_q == '0));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      epoch_q    <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        BOOT:    state_q <= redir ? BUBBLE : RUN;
        RUN:     state_q <= redir ? BUBBLE : RUN;
        BUBBLE:  state_q <= redir ? BUBBLE : RUN;
        default: state_q <= BOOT;
      endcase
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign pc_o        = pc_q;
  assign out_epoch_o = epoch_q;
  assign inflight_o  = inflight_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_pc_gen;
  localparam logic [31:0] RV = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] pc, upc = '0, trap_pc = '0;
  logic [1:0]  out_epoch, inflight;
  logic        jump = 1'b0, trap_valid = 1'b0, resp_done = 1'b0, err;

  int tests_run = 0;
  int fails = 0;

  // Reference model: a request may issue only once an edge has passed since reset
  // and the previous edge carried no redirect.
  logic [31:0] m_pc;
  int          m_epoch, m_inf;
  bit          m_err, m_started, m_block;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk_i(clk), .rst_ni(rst_n),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .pc_o(pc), .out_epoch_o(out_epoch),
    .jump_i(jump), .upc_i(upc),
    .trap_valid_i(trap_valid), .trap_pc_i(trap_pc),
    .resp_done_i(resp_done), .inflight_o(inflight), .err_o(err)
  );

  function automatic bit m_valid();
    return m_started && !m_block && !(trap_valid || jump) && (m_inf < 2);
  endfunction

  task automatic model_init();
    m_pc = RV; m_epoch = 0; m_inf = 0; m_err = 0; m_started = 0; m_block = 0;
  endtask

  task automatic model_edge();
    bit r, f, d;
    r = trap_valid || jump;
    f = m_valid() && out_ready;
    d = resp_done && (m_inf != 0);
    if (r) begin
      m_pc    = (trap_valid ? trap_pc : upc) & ~32'd3;
      m_epoch = (m_epoch + 1) % 4;
    end else if (f) begin
      m_pc = m_pc + 32'd4;
    end
    if (resp_done && m_inf == 0) m_err = 1;
    m_inf     = m_inf + int'(f) - int'(d);
    m_block   = r;
    m_started = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    out_ready = 0; jump = 0; trap_valid = 0; resp_done = 0; upc = '0; trap_pc = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    model_init();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    apply_reset();
    out_ready = 1; resp_done = 1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || pc !== RV || out_epoch !== 2'd0 || inflight !== 2'd0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: valid=%b pc=%h epoch=%0d inflight=%0d err=%b, want 0 %h 0 0 0",
               out_valid, pc, out_epoch, inflight, err, RV);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || pc !== RV + 32'(4 * i) || out_epoch !== 2'd0) begin
        fails++;
        $display("FAIL reset_seq[%0d]: valid=%b pc=%h epoch=%0d, want 1 %h 0",
                 i, out_valid, pc, out_epoch, RV + 32'(4 * i));
      end
      tick();
    end
  endtask

  task automatic test_credit();
    apply_reset();
    out_ready = 1;
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || pc !== RV + 32'(4 * i)) begin
        fails++;
        $display("FAIL credit_fire[%0d]: valid=%b pc=%h, want 1 %h", i, out_valid, pc, RV + 32'(4 * i));
      end
      tick();
    end
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || inflight !== 2'd2) begin
      fails++;
      $display("FAIL credit_full: valid=%b inflight=%0d, want 0 2", out_valid, inflight);
    end
    resp_done = 1;
    tick();
    resp_done = 0;
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || pc !== RV + 32'd8 || inflight !== 2'd1) begin
      fails++;
      $display("FAIL credit_return: valid=%b pc=%h inflight=%0d, want 1 %h 1", out_valid, pc, inflight, RV + 32'd8);
    end
    tick();
  endtask

  task automatic test_jump();
    resp_done = 1;
    tick();
    resp_done = 0;
    jump = 1; upc = 32'h8000_0013;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || inflight !== 2'd1) begin
      fails++;
      $display("FAIL jump_cycle: valid=%b inflight=%0d, want 0 1", out_valid, inflight);
    end
    tick();
    jump = 0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || pc !== 32'h8000_0010 || out_epoch !== 2'd1) begin
      fails++;
      $display("FAIL jump_bubble: valid=%b pc=%h epoch=%0d, want 0 80000010 1", out_valid, pc, out_epoch);
    end
    tick();
    #1;
    tests_run++;
    if (out_valid !== 1'b1 || pc !== 32'h8000_0010 || out_epoch !== 2'd1 || inflight !== 2'd1) begin
      fails++;
      $display("FAIL jump_resume: valid=%b pc=%h epoch=%0d inflight=%0d, want 1 80000010 1 1",
               out_valid, pc, out_epoch, inflight);
    end
    tick();
  endtask

  task automatic test_priority();
    apply_reset();
    out_ready = 1;
    tick();
    trap_valid = 1; trap_pc = 32'h8000_1000; jump = 1; upc = 32'h8000_0200;
    tick();
    trap_valid = 0; jump = 0;
    #1;
    tests_run++;
    if (pc !== 32'h8000_1000 || out_epoch !== 2'd1) begin
      fails++;
      $display("FAIL priority: pc=%h epoch=%0d, want 80001000 1", pc, out_epoch);
    end
    for (int i = 0; i < 4; i++) begin
      jump = 1; upc = $urandom;
      tick();
    end
    jump = 0;
    #1;
    tests_run++;
    if (out_epoch !== 2'd1 || pc !== m_pc) begin
      fails++;
      $display("FAIL epoch_wrap: epoch=%0d pc=%h, want 1 %h", out_epoch, pc, m_pc);
    end
    tick();
  endtask

  task automatic test_stall();
    apply_reset();
    out_ready = 1;
    tick();
    tick();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || pc !== RV + 32'd4 || out_epoch !== 2'd0) begin
        fails++;
        $display("FAIL stall[%0d]: valid=%b pc=%h epoch=%0d, want 1 %h 0", i, out_valid, pc, out_epoch, RV + 32'd4);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1; jump = 1; upc = 32'h0000_4000;
    tick();
    jump = 0;
    tick(); tick(); tick();
    #3;
    rst_n = 0;
    model_init();
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || pc !== RV || out_epoch !== 2'd0 || inflight !== 2'd0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: valid=%b pc=%h epoch=%0d inflight=%0d err=%b, want 0 %h 0 0 0",
               out_valid, pc, out_epoch, inflight, err, RV);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
  endtask

  task automatic test_error();
    apply_reset();
    tick();
    resp_done = 1;
    tick();
    resp_done = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      tests_run++;
      if (err !== 1'b1) begin
        fails++;
        $display("FAIL err_sticky[%0d]: err=%b, want 1", i, err);
      end
      out_ready = 1'($urandom); resp_done = 1'($urandom);
      tick();
    end
    #3;
    rst_n = 0;
    #1;
    tests_run++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_reset: err=%b, want 0", err);
    end
    apply_reset();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      out_ready  = ($urandom_range(3) != 0);
      jump       = ($urandom_range(9) == 0);
      upc        = $urandom;
      trap_valid = ($urandom_range(15) == 0);
      trap_pc    = $urandom;
      resp_done  = (m_inf > 0) ? 1'($urandom) : ($urandom_range(49) == 0);
      #1;
      tests_run++;
      if (out_valid !== m_valid() || pc !== m_pc || out_epoch !== 2'(m_epoch) ||
          inflight !== 2'(m_inf) || err !== m_err) begin
        fails++;
        $display("FAIL random[%0d]: valid=%b pc=%h epoch=%0d inflight=%0d err=%b, want %b %h %0d %0d %b",
                 i, out_valid, pc, out_epoch, inflight, err, m_valid(), m_pc, m_epoch, m_inf, m_err);
      end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_init();
    test_reset();
    test_credit();
    test_jump();
    test_priority();
    test_stall();
    test_reset_mid();
    test_error();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator: the next-generation PC unit at the front of the pipelined core. It drives the fetch stage over a valid/ready handshake and accepts two redirect sources: trap (highest priority) and branch/jump. It limits in-flight fetches with a credit counter, and tags each issued PC with an epoch so downstream stages can drop wrong-path responses after a redirect.

## Interface
- DATA_WIDTH, 32: PC width.
- RESET_VECTOR, 32'h3000_0000: PC value after reset.
- STEP, 4: increment per issued fetch, in bytes. Must be a power of two, ≥ 1.
- MAX_OUTSTANDING, 2: maximum issued-but-unreturned fetches (≥ 1).
- EPOCH_WIDTH, 2: epoch tag width (≥ 1).

- clock  in  1  single clock; all state is updated on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- out_valid  out  1  `pc` is a fetch request.
- out_ready  in  1  fetch stage accepts the request.
- pc  out  DATA_WIDTH  current fetch address.
- out_epoch  out  EPOCH_WIDTH  epoch of `pc`.
- jump  in  1  branch/jump redirect request.
- upc  in  DATA_WIDTH  jump target.
- trap_valid  in  1  trap/mret redirect request; has priority over `jump`.
- trap_pc  in  DATA_WIDTH  trap target.
- resp_done  in  1  one previously issued fetch has completed (any epoch).
- inflight  out  clog2(MAX_OUTSTANDING+1)  outstanding-fetch count.
- err  out  1  sticky error flag: `resp_done` arrived while `inflight == 0`.

## Operation
- States: BOOT, RUN, BUBBLE. Reset forces BOOT.
- Reset values: pc = RESET_VECTOR, out_epoch = 0, inflight = 0, err = 0, out_valid = 0.
- Definitions:
  - redir = trap_valid | jump
  - target = trap_valid ? trap_pc : upc, with the low log2(STEP) bits forced to 0
  - fire = out_valid & out_ready
- out_valid is combinational: (state == RUN) & !redir & (inflight < MAX_OUTSTANDING).
  - No bypass from `resp_done` into `out_valid`.
  - `out_valid` is never asserted in the same cycle as `redir`, so `fire` and a redirect never coincide.
- State transitions:
  - BOOT → RUN on the next edge, or → BUBBLE if `redir` is high.
  - RUN → BUBBLE on `redir`; otherwise stays in RUN.
  - BUBBLE → RUN when `!redir`. A new `redir` in BUBBLE stays in BUBBLE and is applied.
- On a `redir` edge, in any state:
  - pc <= target
  - out_epoch <= out_epoch + 1, modulo 2^EPOCH_WIDTH
- On a `fire` edge: pc <= pc + STEP, modulo 2^DATA_WIDTH (wraps silently).
- Otherwise `pc` holds. It holds while out_valid is high and out_ready is low; `pc` and `out_epoch` must stay stable during that stall.
- inflight <= inflight + fire - (resp_done & inflight != 0).
  - A simultaneous `fire` and `resp_done` leaves `inflight` unchanged.
  - Redirects do not clear `inflight`; wrong-path responses still return their credit.
- err <= 1 when `resp_done` arrives with `inflight == 0`. It clears only on reset.

## Timing
- Reset assertion clears all state immediately, without waiting for a clock edge. Reset may assert mid-operation; no state is carried across it.
- After reset deasserts:
  - Edge 1: BOOT → RUN.
  - `out_valid` is high from edge 1, first `pc` = RESET_VECTOR.
- Fetch rate: with `out_ready` high and credits available, one request per cycle and `pc` advances every edge.
- Redirect latency:
  - The new target is on `pc` one edge after `redir`.
  - `out_valid` is low in the `redir` cycle and in the BUBBLE cycle, then high one cycle after the redirect edge.
  - Penalty: two cycles without a request.
- Credit return: `resp_done` at edge N frees a credit, so `out_valid` can rise in the cycle after edge N.

## Test plan
- Reset vector: release `reset` with `out_ready` = 1 and `resp_done` asserted each cycle.
  - Required: `out_valid` rises after the first edge.
  - Required: `pc` = 0x30000000, 0x30000004, 0x30000008 on consecutive cycles; `out_epoch` = 0.
- Credit limit: MAX_OUTSTANDING = 2, `out_ready` = 1, no `resp_done`.
  - Required: two fires (0x30000000, 0x30000004), then `out_valid` = 0 and `inflight` = 2.
  - Pulse `resp_done` once → one more fire at 0x30000008.
- Jump: `jump` = 1, `upc` = 0x80000013 in RUN.
  - Required: `out_valid` = 0 for 2 cycles, then `pc` = 0x80000010, `out_epoch` = 1.
  - Required: `inflight` unchanged by the jump.
- Priority: assert `trap_valid` (`trap_pc` = 0x80001000) and `jump` (`upc` = 0x80000200) in the same cycle.
  - Required: `pc` = 0x80001000 and a single epoch increment.
  - Then 4 further redirects → `out_epoch` wraps to 1.
- Stall, reset, and error:
  - Hold `out_ready` = 0 for 5 cycles → `pc` and `out_epoch` stable.
  - Assert `reset` mid-stream, off the clock edge → all outputs return to reset values at once.
  - `resp_done` with `inflight` = 0 → `err` = 1 and stays set until reset.
